// File: rtl/slot_capture_pkg.sv
// Shared types and helpers for the multi-slot ADC capture path.
package slot_capture_pkg;

   localparam logic [2:0] ST_IDLE     = 3'd0;
   localparam logic [2:0] ST_SETTLE   = 3'd1;
   localparam logic [2:0] ST_TRIG     = 3'd2;
   localparam logic [2:0] ST_WAIT_EOC = 3'd3;
   localparam logic [2:0] ST_STORE    = 3'd4;
   localparam logic [2:0] ST_PUSH     = 3'd5;

   typedef enum logic [2:0] {
      IDLE     = ST_IDLE,
      SETTLE   = ST_SETTLE,
      TRIG     = ST_TRIG,
      WAIT_EOC = ST_WAIT_EOC,
      STORE    = ST_STORE,
      PUSH     = ST_PUSH
   } state_t;

   localparam int unsigned STAT_W = 16;

   function automatic int unsigned frame_w(input int unsigned data_w, input int unsigned num_slots);
      return data_w * num_slots;
   endfunction

   // Increment that sticks at all-ones instead of wrapping.
   function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] v);
      return (v == '1) ? v : v + STAT_W'(1);
   endfunction

endpackage

// File: rtl/sync_fifo_sc.sv
// Single-clock FIFO with registered full/empty/level and registered read data.
module sync_fifo_sc #(
   parameter int unsigned DEPTH  = 128,
   parameter int unsigned ADDR_W = 7,
   parameter int unsigned WIDTH  = 20
) (
   input  logic              ctrl_clk,
   input  logic              rst,
   input  logic              wr_en,
   input  logic [WIDTH-1:0]  wr_data,
   input  logic              rd_en,
   output logic [WIDTH-1:0]  rd_data,
   output logic              rd_valid,
   output logic              full,
   output logic              empty,
   output logic [ADDR_W:0]   level
);

   localparam int unsigned PTR_W = ADDR_W + 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr, rd_ptr;
   logic [PTR_W-1:0] wr_ptr_d, rd_ptr_d, level_d;
   logic             do_pop, do_push;

   // A push into a full FIFO is only taken when a pop frees a slot in the same cycle.
   always_comb begin
      do_pop   = rd_en && !empty;
      do_push  = wr_en && (!full || do_pop);
      wr_ptr_d = wr_ptr + PTR_W'(do_push);
      rd_ptr_d = rd_ptr + PTR_W'(do_pop);
      level_d  = wr_ptr_d - rd_ptr_d;
   end

   always_ff @(posedge ctrl_clk) begin
      if (rst) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         level    <= '0;
         empty    <= 1'b1;
         full     <= 1'b0;
         rd_valid <= 1'b0;
         rd_data  <= '0;
      end else begin
         wr_ptr   <= wr_ptr_d;
         rd_ptr   <= rd_ptr_d;
         level    <= level_d;
         empty    <= (level_d == '0);
         full     <= (level_d == PTR_W'(DEPTH));
         rd_valid <= do_pop;
         if (do_pop) rd_data <= mem[rd_ptr[ADDR_W-1:0]];
      end
   end

   always_ff @(posedge ctrl_clk) begin
      if (do_push && !rst) mem[wr_ptr[ADDR_W-1:0]] <= wr_data;
   end

endmodule

// File: rtl/multi_slot_capture.sv
// Multi-slot ADC frame capture: slot FSM, frame assembly, sticky flags, frame FIFO.
// Optional SLOT_CAPTURE_STATS_EN adds saturating drop/timeout counters.
module multi_slot_capture
   import slot_capture_pkg::*;
#(
   parameter int unsigned DATA_W    = 10,
   parameter int unsigned NUM_SLOTS = 2,
   parameter int unsigned DEPTH     = 128,
   parameter int unsigned ADDR_W    = 7,
   parameter int unsigned DLY_W     = 5,
   parameter int unsigned TMO_W     = 6
) (
   input  logic                          ctrl_clk,
   input  logic                          rst,
   input  logic                          slot_start,
   input  logic                          slot_next,
   input  logic [DLY_W-1:0]              settle_dly,
   input  logic [TMO_W-1:0]              eoc_timeout,
   output logic                          adc_trigger,
   input  logic                          adc_eoc,
   input  logic [DATA_W-1:0]             adc_data,
   output logic                          busy,
   input  logic                          rd_en,
   output logic [NUM_SLOTS*DATA_W-1:0]   rd_data,
   output logic                          rd_valid,
   output logic                          full,
   output logic                          empty,
   output logic [ADDR_W:0]               level,
   input  logic                          clr_flags,
   output logic                          overflow,
   output logic                          timeout_err,
   output logic                          late_slot
`ifdef SLOT_CAPTURE_STATS_EN
   ,
   output logic [STAT_W-1:0]             drop_cnt,
   output logic [STAT_W-1:0]             tmo_cnt
`endif
);

   localparam int unsigned FRAME_W = frame_w(DATA_W, NUM_SLOTS);
   localparam int unsigned SLOT_W  = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;
   localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(NUM_SLOTS - 1);

   state_t              state, state_d;
   logic [DLY_W-1:0]    settle_cnt, settle_cnt_d;
   logic [TMO_W-1:0]    eoc_cnt, eoc_cnt_d;
   logic [SLOT_W-1:0]   slot_idx, slot_idx_d;
   logic [DATA_W-1:0]   sample, sample_d;
   logic [FRAME_W-1:0]  frame, frame_d;
   logic                push_c, tmo_set, late_set, drop;

   // Next-state logic; a slot_start outside IDLE overrides whatever the state decided.
   always_comb begin
      state_d      = state;
      settle_cnt_d = settle_cnt;
      eoc_cnt_d    = eoc_cnt;
      slot_idx_d   = slot_idx;
      sample_d     = sample;
      frame_d      = frame;
      push_c       = 1'b0;
      tmo_set      = 1'b0;
      late_set     = (state != IDLE) && slot_next;

      case (state)
         IDLE: begin
            if (slot_start) begin
               state_d      = SETTLE;
               slot_idx_d   = '0;
               settle_cnt_d = settle_dly;
            end else if (slot_next) begin
               state_d      = SETTLE;
               settle_cnt_d = settle_dly;
            end
         end
         SETTLE: begin
            if (settle_cnt == '0) state_d = TRIG;
            else                  settle_cnt_d = settle_cnt - DLY_W'(1);
         end
         TRIG: begin
            state_d   = WAIT_EOC;
            eoc_cnt_d = eoc_timeout;
         end
         WAIT_EOC: begin
            if (adc_eoc) begin
               sample_d = adc_data;
               state_d  = STORE;
            end else if (eoc_cnt == '0) begin
               sample_d = '0;
               tmo_set  = 1'b1;
               state_d  = STORE;
            end else begin
               eoc_cnt_d = eoc_cnt - TMO_W'(1);
            end
         end
         STORE: begin
            for (int i = 0; i < int'(NUM_SLOTS); i++) begin
               if (slot_idx == SLOT_W'(i))
                  frame_d[(int'(NUM_SLOTS) - 1 - i) * int'(DATA_W) +: DATA_W] = sample;
            end
            if (slot_idx == LAST_SLOT) begin
               state_d = PUSH;
            end else begin
               slot_idx_d = slot_idx + SLOT_W'(1);
               state_d    = IDLE;
            end
         end
         PUSH: begin
            push_c     = 1'b1;
            slot_idx_d = '0;
            state_d    = IDLE;
         end
         default: state_d = IDLE;
      endcase

      if ((state != IDLE) && slot_start) begin
         state_d      = SETTLE;
         slot_idx_d   = '0;
         settle_cnt_d = settle_dly;
         push_c       = 1'b0;
         tmo_set      = 1'b0;
      end

      drop = push_c && full && !rd_en;
   end

   always_ff @(posedge ctrl_clk) begin
      if (rst) begin
         state       <= IDLE;
         settle_cnt  <= '0;
         eoc_cnt     <= '0;
         slot_idx    <= '0;
         sample      <= '0;
         frame       <= '0;
         adc_trigger <= 1'b0;
         busy        <= 1'b0;
      end else begin
         state       <= state_d;
         settle_cnt  <= settle_cnt_d;
         eoc_cnt     <= eoc_cnt_d;
         slot_idx    <= slot_idx_d;
         sample      <= sample_d;
         frame       <= frame_d;
         adc_trigger <= (state_d == TRIG);
         busy        <= (state_d != IDLE);
      end
   end

   // Sticky flags: clear wins over a set in the same cycle.
   always_ff @(posedge ctrl_clk) begin
      if (rst) begin
         overflow    <= 1'b0;
         timeout_err <= 1'b0;
         late_slot   <= 1'b0;
      end else begin
         overflow    <= (overflow    | drop)     & ~clr_flags;
         timeout_err <= (timeout_err | tmo_set)  & ~clr_flags;
         late_slot   <= (late_slot   | late_set) & ~clr_flags;
      end
   end

`ifdef SLOT_CAPTURE_STATS_EN
   always_ff @(posedge ctrl_clk) begin
      if (rst || clr_flags) begin
         drop_cnt <= '0;
         tmo_cnt  <= '0;
      end else begin
         if (drop)    drop_cnt <= sat_inc(drop_cnt);
         if (tmo_set) tmo_cnt  <= sat_inc(tmo_cnt);
      end
   end
`endif

   sync_fifo_sc #(
      .DEPTH  (DEPTH),
      .ADDR_W (ADDR_W),
      .WIDTH  (FRAME_W)
   ) u_fifo (
      .ctrl_clk (ctrl_clk),
      .rst      (rst),
      .wr_en    (push_c),
      .wr_data  (frame),
      .rd_en    (rd_en),
      .rd_data  (rd_data),
      .rd_valid (rd_valid),
      .full     (full),
      .empty    (empty),
      .level    (level)
   );

endmodule

// File: tb/tb_multi_slot_capture.sv
// Directed + randomized bench for multi_slot_capture against a frame-level queue model.
module tb_multi_slot_capture;

   localparam int DATA_W    = 10;
   localparam int NUM_SLOTS = 2;
   localparam int DEPTH     = 128;
   localparam int ADDR_W    = 7;
   localparam int FRAME_W   = DATA_W * NUM_SLOTS;

   logic                 ctrl_clk = 1'b0;
   logic                 rst, slot_start, slot_next, adc_eoc, rd_en, clr_flags;
   logic [4:0]           settle_dly;
   logic [5:0]           eoc_timeout;
   logic [DATA_W-1:0]    adc_data;
   logic                 adc_trigger, busy, rd_valid, full, empty;
   logic                 overflow, timeout_err, late_slot;
   logic [FRAME_W-1:0]   rd_data;
   logic [ADDR_W:0]      level;
`ifdef SLOT_CAPTURE_STATS_EN
   logic [15:0]          drop_cnt, tmo_cnt;
`endif

   always #5 ctrl_clk = ~ctrl_clk;

   multi_slot_capture dut (
      .ctrl_clk    (ctrl_clk),
      .rst         (rst),
      .slot_start  (slot_start),
      .slot_next   (slot_next),
      .settle_dly  (settle_dly),
      .eoc_timeout (eoc_timeout),
      .adc_trigger (adc_trigger),
      .adc_eoc     (adc_eoc),
      .adc_data    (adc_data),
      .busy        (busy),
      .rd_en       (rd_en),
      .rd_data     (rd_data),
      .rd_valid    (rd_valid),
      .full        (full),
      .empty       (empty),
      .level       (level),
      .clr_flags   (clr_flags),
      .overflow    (overflow),
      .timeout_err (timeout_err),
      .late_slot   (late_slot)
`ifdef SLOT_CAPTURE_STATS_EN
      ,
      .drop_cnt    (drop_cnt),
      .tmo_cnt     (tmo_cnt)
`endif
   );

   int n_cmp = 0;
   int n_bad = 0;

   // Reference model: frames as a queue, current partial frame as an array of samples.
   logic [FRAME_W-1:0] exp_q[$];
   logic [DATA_W-1:0]  cur[NUM_SLOTS];
   int                 cur_idx;
   bit                 m_ovf, m_tmo, m_late;
   int                 m_drop, m_tmocnt;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [FRAME_W-1:0] frame_word();
      logic [FRAME_W-1:0] w = '0;
      for (int i = 0; i < NUM_SLOTS; i++) w = (w << DATA_W) | FRAME_W'(cur[i]);
      return w;
   endfunction

   function automatic void model_push(input logic [FRAME_W-1:0] w);
      if (exp_q.size() < DEPTH) exp_q.push_back(w);
      else begin
         m_ovf = 1;
         m_drop++;
      end
   endfunction

   function automatic void model_reset();
      exp_q.delete();
      cur_idx = 0;
      m_ovf = 0; m_tmo = 0; m_late = 0;
      m_drop = 0; m_tmocnt = 0;
   endfunction

   task automatic check_flags(input string tag);
      check({tag, "_overflow"},    32'(overflow),    32'(m_ovf));
      check({tag, "_timeout_err"}, 32'(timeout_err), 32'(m_tmo));
      check({tag, "_late_slot"},   32'(late_slot),   32'(m_late));
`ifdef SLOT_CAPTURE_STATS_EN
      check({tag, "_drop_cnt"},    32'(drop_cnt),    32'(m_drop));
      check({tag, "_tmo_cnt"},     32'(tmo_cnt),     32'(m_tmocnt));
`endif
   endtask

   // Pulse a slot strobe with the given config and check the pulse-to-trigger latency.
   task automatic pulse_and_trig(input bit is_start, input int dly, input int tmo);
      int n = 0;
      bit seen = 0;
      @(negedge ctrl_clk);
      settle_dly  = 5'(dly);
      eoc_timeout = 6'(tmo);
      if (is_start) slot_start = 1'b1;
      else          slot_next  = 1'b1;
      while (!seen && n < 80) begin
         @(negedge ctrl_clk);
         slot_start = 1'b0;
         slot_next  = 1'b0;
         n++;
         if (adc_trigger) seen = 1;
      end
      check("trig_latency", 32'(n), 32'(dly + 2));
   endtask

   // One full slot: strobe, trigger, eoc d cycles after trigger (0 = none), model update.
   task automatic slot(input bit is_start, input int dly, input int tmo, input int d,
                       input logic [DATA_W-1:0] data, input bit pop_at_push);
      bit hit;
      bit last;
      int n = 0;
      logic [FRAME_W-1:0] w;
      pulse_and_trig(is_start, dly, tmo);
      if (is_start) cur_idx = 0;
      hit = (d >= 1) && (d <= tmo + 1);
      if (d > 0) begin
         repeat (d) @(negedge ctrl_clk);
         adc_eoc  = 1'b1;
         adc_data = data;
         @(negedge ctrl_clk);
         adc_eoc  = 1'b0;
         adc_data = DATA_W'($urandom);
      end
      if (!hit) begin
         m_tmo = 1;
         m_tmocnt++;
      end
      cur[cur_idx] = hit ? data : '0;
      last = (cur_idx == NUM_SLOTS - 1);
      if (last) begin
         w = frame_word();
         if (pop_at_push && hit) begin
            @(negedge ctrl_clk);
            rd_en = 1'b1;
            @(negedge ctrl_clk);
            rd_en = 1'b0;
            check("push_pop_valid", 32'(rd_valid), 32'd1);
            check("push_pop_data", 32'(rd_data), 32'(exp_q.pop_front()));
            exp_q.push_back(w);
         end else begin
            model_push(w);
         end
         cur_idx = 0;
      end else begin
         cur_idx++;
      end
      while (busy && n < 80) begin
         @(negedge ctrl_clk);
         n++;
      end
      check("slot_done", 32'(busy), 32'd0);
   endtask

   task automatic rand_frame();
      for (int s = 0; s < NUM_SLOTS; s++) begin
         int dly = $urandom_range(0, 3);
         int tmo = $urandom_range(0, 3);
         slot(s == 0, dly, tmo, $urandom_range(0, tmo + 3), DATA_W'($urandom_range(1, 1023)), 0);
      end
   endtask

   task automatic pop_chk(input string tag);
      @(negedge ctrl_clk);
      rd_en = 1'b1;
      @(negedge ctrl_clk);
      rd_en = 1'b0;
      if (exp_q.size() > 0) begin
         check({tag, "_valid"}, 32'(rd_valid), 32'd1);
         check({tag, "_data"},  32'(rd_data),  32'(exp_q.pop_front()));
      end else begin
         check({tag, "_valid_empty"}, 32'(rd_valid), 32'd0);
      end
   endtask

   task automatic clr();
      @(negedge ctrl_clk);
      clr_flags = 1'b1;
      @(negedge ctrl_clk);
      clr_flags = 1'b0;
      m_ovf = 0; m_tmo = 0; m_late = 0;
      m_drop = 0; m_tmocnt = 0;
   endtask

   initial begin
      logic [FRAME_W-1:0] held;
      rst = 1'b1; slot_start = 1'b0; slot_next = 1'b0; adc_eoc = 1'b0; rd_en = 1'b0;
      clr_flags = 1'b0; settle_dly = '0; eoc_timeout = '0; adc_data = '0;
      model_reset();
      repeat (3) @(negedge ctrl_clk);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_trigger", 32'(adc_trigger), 32'd0);
      check("rst_empty", 32'(empty), 32'd1);
      check("rst_full", 32'(full), 32'd0);
      check("rst_level", 32'(level), 32'd0);
      check("rst_rd_valid", 32'(rd_valid), 32'd0);
      check("rst_rd_data", 32'(rd_data), 32'd0);
      check_flags("rst");
      rst = 1'b0;

      // Two-slot frame with both samples captured.
      slot(1, 3, 7, 4, 10'h2A5, 0);
      slot(0, 3, 7, 4, 10'h15A, 0);
      check("s1_level", 32'(level), 32'd1);
      pop_chk("s1_pop");
      held = rd_data;
      @(negedge ctrl_clk);
      check("s1_valid_drop", 32'(rd_valid), 32'd0);
      check("s1_data_hold", 32'(rd_data), 32'(held));
      check_flags("s1");

      // Second slot times out and is zero-filled.
      slot(1, 3, 7, 4, 10'h2A5, 0);
      slot(0, 3, 7, 0, 10'h000, 0);
      check_flags("s2");
      pop_chk("s2_pop");
      clr();
      check_flags("s2_clr");

      // Overfill by two frames, then drain in order.
      for (int f = 0; f < DEPTH + 2; f++) rand_frame();
      check("s3_full", 32'(full), 32'd1);
      check("s3_level", 32'(level), 32'(DEPTH));
      check_flags("s3");
      for (int p = 0; p < DEPTH; p++) pop_chk("s3_pop");
      check("s3_empty", 32'(empty), 32'd1);
      check("s3_level0", 32'(level), 32'd0);
      pop_chk("s3_pop_empty");
      check("s3_level_after_empty_pop", 32'(level), 32'd0);

      // Frame pushed into a full FIFO in the same cycle as a pop.
      clr();
      for (int f = 0; f < DEPTH; f++) rand_frame();
      check("s4_full_before", 32'(full), 32'd1);
      slot(1, 1, 7, 2, DATA_W'($urandom_range(1, 1023)), 0);
      slot(0, 1, 7, 3, DATA_W'($urandom_range(1, 1023)), 1);
      check("s4_level", 32'(level), 32'(DEPTH));
      check("s4_full", 32'(full), 32'd1);
      check_flags("s4");
      for (int p = 0; p < DEPTH; p++) pop_chk("s4_pop");
      check("s4_empty", 32'(empty), 32'd1);

      // Abort in WAIT_EOC of slot 1, plus a late slot_next.
      clr();
      slot(1, 2, 7, 1, DATA_W'($urandom_range(1, 1023)), 0);
      pulse_and_trig(0, 2, 7);
      @(negedge ctrl_clk);
      slot_next = 1'b1;
      m_late = 1;
      @(negedge ctrl_clk);
      slot_next = 1'b0;
      slot(1, 2, 7, 3, DATA_W'($urandom_range(1, 1023)), 0);
      check("s5_no_push", 32'(level), 32'd0);
      slot(0, 0, 5, 6, DATA_W'($urandom_range(1, 1023)), 0);
      check("s5_level", 32'(level), 32'd1);
      check_flags("s5");

      // Reset mid-frame with five entries queued.
      for (int f = 0; f < 4; f++) rand_frame();
      check("s6_level5", 32'(level), 32'd5);
      pulse_and_trig(1, 1, 7);
      @(negedge ctrl_clk);
      rst = 1'b1;
      @(negedge ctrl_clk);
      model_reset();
      check("s6_busy", 32'(busy), 32'd0);
      check("s6_level", 32'(level), 32'd0);
      check("s6_empty", 32'(empty), 32'd1);
      check("s6_full", 32'(full), 32'd0);
      check("s6_rd_data", 32'(rd_data), 32'd0);
      check_flags("s6");
      rst = 1'b0;
      rand_frame();
      pop_chk("s6_pop_after_rst");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
